// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline sequencing controller for the 32-bit R/I/J CPU.
// Turns the IF/ID hazard flag, EX branch resolution and halt/resume requests
// into PC / IF/ID write enables and NOP (32'hFFFF_FFFF) injection controls.
// A detected hazard is held for the full STALL_CYCLES write-back distance,
// since the hazard flag drops as soon as the producer leaves ID.
// Optional macro: PIPE_CTRL_STALL_PERF_EN builds the 16-bit saturating
// hazard-stall counter on stall_cnt; otherwise stall_cnt is tied to zero.
module pipeline_ctrl #(
  parameter int unsigned STALL_CYCLES = 2,  // 1..15, includes detection cycle
  parameter int unsigned FLUSH_CYCLES = 1   // 1..15, includes branch cycle
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        if_flush,
  output logic        id_bubble,
  output logic        halted,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Counter reload values: the first cycle of a stall/flush is spent in RUN
  // (or the current state), so the dedicated state covers the remaining N-1
  // cycles and the counter runs N-2 down to 0.
  localparam logic [3:0] STALL_LOAD = (STALL_CYCLES > 1) ? 4'(STALL_CYCLES - 2) : 4'd0;
  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam bit         STALL_MULTI = (STALL_CYCLES > 1);
  localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pc_we_c;
  logic       if_flush_c;
  logic       id_bubble_c;
  logic       stall_ev;

  // Next-state and same-cycle output decode from state, counter and inputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_we_c     = 1'b1;
    if_flush_c  = 1'b0;
    id_bubble_c = 1'b0;
    stall_ev    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          if_flush_c  = 1'b1;
          id_bubble_c = 1'b1;
          state_d     = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
          cnt_d       = FLUSH_LOAD;
        end else if (halt_req) begin
          pc_we_c     = 1'b0;
          id_bubble_c = 1'b1;
          state_d     = ST_HALT;
        end else if (hazard) begin
          pc_we_c     = 1'b0;
          id_bubble_c = 1'b1;
          stall_ev    = 1'b1;
          state_d     = STALL_MULTI ? ST_STALL : ST_RUN;
          cnt_d       = STALL_LOAD;
        end
      end

      ST_STALL: begin
        if (branch_taken) begin
          // The stalled instruction is squashed, so the stall is abandoned.
          if_flush_c  = 1'b1;
          id_bubble_c = 1'b1;
          state_d     = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
          cnt_d       = FLUSH_LOAD;
        end else begin
          pc_we_c     = 1'b0;
          id_bubble_c = 1'b1;
          stall_ev    = 1'b1;
          if (cnt_q == 4'd0) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end

      ST_FLUSH: begin
        if_flush_c = 1'b1;
        if (branch_taken) begin
          id_bubble_c = 1'b1;
          state_d     = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
          cnt_d       = FLUSH_LOAD;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_HALT: begin
        pc_we_c     = 1'b0;
        id_bubble_c = 1'b1;
        if (resume) state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase

    // Reset fills the pipe with NOPs regardless of state.
    if (!rst_n) begin
      pc_we_c     = 1'b0;
      if_flush_c  = 1'b1;
      id_bubble_c = 1'b1;
      stall_ev    = 1'b0;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_we     = pc_we_c;
  assign ifid_we   = pc_we_c;
  assign if_flush  = if_flush_c;
  assign id_bubble = id_bubble_c;
  assign halted    = rst_n && (state_q == ST_HALT);
  assign state_o   = state_q;

`ifdef PIPE_CTRL_STALL_PERF_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of hazard-stall cycles; halts are not counted.
  always_ff @(posedge clk) begin
    if (!rst_n)                                stall_cnt_q <= 16'h0000;
    else if (stall_ev && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_stall_ev;
  assign unused_stall_ev = stall_ev;
  assign stall_cnt       = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table-driven directed test of pipeline_ctrl.
// Instance u_a uses STALL_CYCLES=2/FLUSH_CYCLES=3, instance u_b uses
// STALL_CYCLES=4/FLUSH_CYCLES=1; both share the same stimulus.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic [4:0]  in;       // {rst_n, hazard, branch_taken, halt_req, resume}
    logic [4:0]  exp_out;  // {pc_we, ifid_we, if_flush, id_bubble, halted}
    logic [1:0]  exp_st;
    logic [15:0] exp_perf; // value with the perf counter built
    logic        chk;      // check state/perf (off before first clock edge)
  } vec_t;

`ifdef PIPE_CTRL_STALL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, hazard, branch_taken, halt_req, resume;

  logic        a_pc_we, a_ifid_we, a_if_flush, a_id_bubble, a_halted;
  logic [1:0]  a_state;
  logic [15:0] a_stall_cnt;
  logic        b_pc_we, b_ifid_we, b_if_flush, b_id_bubble, b_halted;
  logic [1:0]  b_state;
  logic [15:0] b_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.STALL_CYCLES(2), .FLUSH_CYCLES(3)) u_a (
    .clk(clk), .rst_n(rst_n), .hazard(hazard), .branch_taken(branch_taken),
    .halt_req(halt_req), .resume(resume), .pc_we(a_pc_we), .ifid_we(a_ifid_we),
    .if_flush(a_if_flush), .id_bubble(a_id_bubble), .halted(a_halted),
    .state_o(a_state), .stall_cnt(a_stall_cnt)
  );

  pipeline_ctrl #(.STALL_CYCLES(4), .FLUSH_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .hazard(hazard), .branch_taken(branch_taken),
    .halt_req(halt_req), .resume(resume), .pc_we(b_pc_we), .ifid_we(b_ifid_we),
    .if_flush(b_if_flush), .id_bubble(b_id_bubble), .halted(b_halted),
    .state_o(b_state), .stall_cnt(b_stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] in, input logic [4:0] eo,
                              input logic [1:0] st, input logic [15:0] pf,
                              input logic chk);
    vec_t v;
    v.in = in; v.exp_out = eo; v.exp_st = st; v.exp_perf = pf; v.chk = chk;
    return v;
  endfunction

  // Drive one cycle of inputs and compare the selected instance's outputs.
  task automatic apply(input vec_t v, input bit use_b, input string tag);
    logic [4:0]  o;
    logic [1:0]  st;
    logic [15:0] pf;
    logic        we_eq;
    @(negedge clk);
    {rst_n, hazard, branch_taken, halt_req, resume} = v.in;
    #1;
    if (use_b) begin
      o = {b_pc_we, b_ifid_we, b_if_flush, b_id_bubble, b_halted};
      st = b_state; pf = b_stall_cnt; we_eq = (b_pc_we == b_ifid_we);
    end else begin
      o = {a_pc_we, a_ifid_we, a_if_flush, a_id_bubble, a_halted};
      st = a_state; pf = a_stall_cnt; we_eq = (a_pc_we == a_ifid_we);
    end
    check({tag, " outs"}, 32'(o), 32'(v.exp_out));
    check({tag, " we_eq"}, 32'(we_eq), 32'd1);
    if (v.chk) begin
      check({tag, " state"}, 32'(st), 32'(v.exp_st));
      check({tag, " stall_cnt"}, 32'(pf), PERF ? 32'(v.exp_perf) : 32'd0);
    end
  endtask

  vec_t tbl_a [35];
  vec_t tbl_b [11];

  initial begin
    {rst_n, hazard, branch_taken, halt_req, resume} = 5'b00000;

    // Instance A (STALL=2, FLUSH=3): in {R,Z,B,H,U}, out {P,I,F,D,L}
    tbl_a[0]  = mk(5'b01000, 5'b00110, 2'd0, 16'd0, 1'b0); // reset, hazard high
    tbl_a[1]  = mk(5'b01000, 5'b00110, 2'd0, 16'd0, 1'b1);
    tbl_a[2]  = mk(5'b01000, 5'b00110, 2'd0, 16'd0, 1'b1);
    tbl_a[3]  = mk(5'b10000, 5'b11000, 2'd0, 16'd0, 1'b1); // RUN after release
    tbl_a[4]  = mk(5'b11000, 5'b00010, 2'd0, 16'd0, 1'b1); // hazard detect
    tbl_a[5]  = mk(5'b10000, 5'b00010, 2'd1, 16'd1, 1'b1); // STALL holds
    tbl_a[6]  = mk(5'b10000, 5'b11000, 2'd0, 16'd2, 1'b1); // resume fetch
    tbl_a[7]  = mk(5'b11000, 5'b00010, 2'd0, 16'd2, 1'b1); // hazard
    tbl_a[8]  = mk(5'b11100, 5'b11110, 2'd1, 16'd3, 1'b1); // branch in STALL
    tbl_a[9]  = mk(5'b10000, 5'b11100, 2'd2, 16'd3, 1'b1); // FLUSH
    tbl_a[10] = mk(5'b11010, 5'b11100, 2'd2, 16'd3, 1'b1); // halt/hazard ignored
    tbl_a[11] = mk(5'b10000, 5'b11000, 2'd0, 16'd3, 1'b1);
    tbl_a[12] = mk(5'b10100, 5'b11110, 2'd0, 16'd3, 1'b1); // branch
    tbl_a[13] = mk(5'b10100, 5'b11110, 2'd2, 16'd3, 1'b1); // re-branch in FLUSH
    tbl_a[14] = mk(5'b10000, 5'b11100, 2'd2, 16'd3, 1'b1);
    tbl_a[15] = mk(5'b10000, 5'b11100, 2'd2, 16'd3, 1'b1);
    tbl_a[16] = mk(5'b10000, 5'b11000, 2'd0, 16'd3, 1'b1); // flush released
    tbl_a[17] = mk(5'b11010, 5'b00010, 2'd0, 16'd3, 1'b1); // halt beats hazard
    tbl_a[18] = mk(5'b11100, 5'b00011, 2'd3, 16'd3, 1'b1); // HALT ignores branch
    tbl_a[19] = mk(5'b10010, 5'b00011, 2'd3, 16'd3, 1'b1);
    tbl_a[20] = mk(5'b10001, 5'b00011, 2'd3, 16'd3, 1'b1); // resume, HALT outs
    tbl_a[21] = mk(5'b10000, 5'b11000, 2'd0, 16'd3, 1'b1); // running again
    tbl_a[22] = mk(5'b10010, 5'b00010, 2'd0, 16'd3, 1'b1); // halt
    tbl_a[23] = mk(5'b10011, 5'b00011, 2'd3, 16'd3, 1'b1); // resume, halt still high
    tbl_a[24] = mk(5'b10010, 5'b00010, 2'd0, 16'd3, 1'b1); // re-enter HALT
    tbl_a[25] = mk(5'b10001, 5'b00011, 2'd3, 16'd3, 1'b1);
    tbl_a[26] = mk(5'b11000, 5'b00010, 2'd0, 16'd3, 1'b1); // hazard
    tbl_a[27] = mk(5'b10010, 5'b00010, 2'd1, 16'd4, 1'b1); // halt not taken in STALL
    tbl_a[28] = mk(5'b10010, 5'b00010, 2'd0, 16'd5, 1'b1); // halt acted on in RUN
    tbl_a[29] = mk(5'b10001, 5'b00011, 2'd3, 16'd5, 1'b1);
    tbl_a[30] = mk(5'b11110, 5'b11110, 2'd0, 16'd5, 1'b1); // branch top priority
    tbl_a[31] = mk(5'b10000, 5'b11100, 2'd2, 16'd5, 1'b1);
    tbl_a[32] = mk(5'b10000, 5'b11100, 2'd2, 16'd5, 1'b1);
    tbl_a[33] = mk(5'b00000, 5'b00110, 2'd0, 16'd5, 1'b1); // reset again
    tbl_a[34] = mk(5'b10000, 5'b11000, 2'd0, 16'd0, 1'b1); // counter cleared

    // Instance B (STALL=4, FLUSH=1): reset mid-STALL, single-cycle flush, long stall
    tbl_b[0]  = mk(5'b11000, 5'b00010, 2'd0, 16'd0, 1'b1);
    tbl_b[1]  = mk(5'b10000, 5'b00010, 2'd1, 16'd1, 1'b1);
    tbl_b[2]  = mk(5'b00000, 5'b00110, 2'd1, 16'd2, 1'b1); // reset mid-STALL
    tbl_b[3]  = mk(5'b10000, 5'b11000, 2'd0, 16'd0, 1'b1);
    tbl_b[4]  = mk(5'b10100, 5'b11110, 2'd0, 16'd0, 1'b1); // branch, stays RUN
    tbl_b[5]  = mk(5'b10000, 5'b11000, 2'd0, 16'd0, 1'b1);
    tbl_b[6]  = mk(5'b11000, 5'b00010, 2'd0, 16'd0, 1'b1);
    tbl_b[7]  = mk(5'b10000, 5'b00010, 2'd1, 16'd1, 1'b1);
    tbl_b[8]  = mk(5'b10000, 5'b00010, 2'd1, 16'd2, 1'b1);
    tbl_b[9]  = mk(5'b10000, 5'b00010, 2'd1, 16'd3, 1'b1);
    tbl_b[10] = mk(5'b10000, 5'b11000, 2'd0, 16'd4, 1'b1);

    for (int i = 0; i < 35; i++) apply(tbl_a[i], 1'b0, $sformatf("a[%0d]", i));
    for (int i = 0; i < 11; i++) apply(tbl_b[i], 1'b1, $sformatf("b[%0d]", i));

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
